mult_div_sequencer: RTL
=======================

MULT_DIV_SEQUENCER -- requirements
Module: mult_div_sequencer

Interface
REQ-001 Port `clock`: input, 1 bit; the single clock; all state is updated on its rising edge.
REQ-002 Port `reset`: input, 1 bit; asynchronous, active-low reset.
REQ-003 Port `start`: input, 1 bit; requests an operation; sampled only in IDLE.
REQ-004 Port `abort`: input, 1 bit; pipeline flush; cancels the operation in flight.
REQ-005 Port `op`: input, 2 bits; 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-006 Port `operandA`: input, 32 bits; multiplicand or dividend (rs).
REQ-007 Port `operandB`: input, 32 bits; multiplier or divisor (rt).
REQ-008 Port `busy`: output, 1 bit; high while in RUN; the hazard unit uses it to stall mfhi/mflo.
REQ-009 Port `done`: output, 1 bit; one-cycle pulse when `hi`/`lo` hold a new result.
REQ-010 Port `hi`: output, 32 bits; HI register (product upper half or remainder).
REQ-011 Port `lo`: output, 32 bits; LO register (product lower half or quotient).
REQ-012 Port `divByZero`: output, 1 bit; sticky flag for the last operation, cleared by the next accepted start.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE; the transitions are:
  - IDLE->RUN on start=1 and abort=0;
  - RUN->DONE when the iteration counter reaches 31;
  - RUN->IDLE on abort;
  - DONE->IDLE unconditionally.
REQ-014 On start acceptance the block SHALL latch op, |operandA| and |operandB| (magnitudes for MULT/DIV, raw values for MULTU/DIVU), plus the result sign bits.
REQ-015 Multiply SHALL be radix-2 shift-add: one multiplier bit per RUN cycle, 64-bit accumulator.
REQ-016 Divide SHALL be radix-2 restoring: one quotient bit per RUN cycle, 33-bit partial remainder.
REQ-017 Latency SHALL be as follows:
  - start sampled at edge E0;
  - RUN occupies cycles E1..E32;
  - hi/lo are written at E33;
  - done=1 during E33..E34;
  - IDLE again at E34.
REQ-018 Signed multiply SHALL negate the 64-bit product when the operand signs differ.
REQ-019 Signed divide SHALL give the quotient the XOR of the operand signs and the remainder the sign of the dividend.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no flag.
REQ-021 Divisor=0 SHALL skip RUN (IDLE->DONE at E1) and give hi=operandA, lo=0xFFFFFFFF, divByZero=1.
REQ-022 start while not in IDLE SHALL be ignored, with no queuing.
REQ-023 abort SHALL take priority over start and over counter completion; hi/lo keep their previous values and no done is produced.
REQ-024 hi/lo SHALL change only in DONE entry, so a stale result stays readable during RUN.

Reset
REQ-025 Asserting reset SHALL asynchronously force IDLE with counter=0, busy=0, done=0, divByZero=0, hi=0, lo=0.
REQ-026 Reset during RUN SHALL discard the operation, and no done SHALL follow.
REQ-027 Deassertion SHALL be treated synchronously; start is first accepted on the first rising edge with reset high.

Configuration
REQ-028 The macro MDU_EARLY_TERM_EN SHALL control early termination of multiplies.
  - Defined: a multiply SHALL enter DONE on the edge after the remaining multiplier bits become all zero; a multiplier of 0 gives DONE at E1. Divide latency is unchanged.
  - Undefined: every multiply SHALL take exactly 32 RUN cycles.

Structure
REQ-029 Package mdu_pkg SHALL hold:
  - the op enum (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU);
  - the state enum (IDLE, RUN, DONE);
  - the constants MDU_WIDTH=32 and MDU_ITER=32.
REQ-030 Sub-module mdu_step SHALL be purely combinational: one shift-add or restoring-subtract iteration; mult_div_sequencer holds all registers and the FSM.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at E33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 MULT 0xFFFFFFFD(-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIVU 100 / 0 -> done at E1, hi=100, lo=0xFFFFFFFF, divByZero=1; the next valid start clears the flag.
REQ-034 Start DIVU 50/7, pulse abort at E10, then hold start during E5..E20 -> no done, hi/lo unchanged, new start accepted only from IDLE.
REQ-035 Assert reset during RUN at E15 -> all outputs 0 immediately; after release, DIVU 50/7 gives lo=7, hi=1.
REQ-036 With MDU_EARLY_TERM_EN defined, MULTU 5 x 3 -> done by E3, lo=15; undefined -> done at E33.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Holds the operation and FSM encodings plus the magnitude helper used at operand capture.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITER  = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mduOp_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mduState_e;

    // Two's-complement magnitude; 0x80000000 maps onto itself, which the unsigned datapath reads as 2^31.
    function automatic logic [MDU_WIDTH-1:0] mduMag(input logic [MDU_WIDTH-1:0] v,
                                                    input logic                 isSigned);
        return (isSigned && v[MDU_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide, purely combinational.
module mdu_step
    import mdu_pkg::*;
(
    input  logic                   i_isDiv,
    input  logic [2*MDU_WIDTH-1:0] i_acc,
    input  logic [2*MDU_WIDTH-1:0] i_opA,
    input  logic [MDU_WIDTH-1:0]   i_opB,
    output logic [2*MDU_WIDTH-1:0] o_acc,
    output logic [2*MDU_WIDTH-1:0] o_opA,
    output logic [MDU_WIDTH-1:0]   o_opB
);

    logic [MDU_WIDTH:0]   w_shifted;
    logic [MDU_WIDTH+1:0] w_diff;
    logic                 w_fits;

    // Multiply: acc holds the product, opA the left-shifting multiplicand, opB the remaining multiplier bits.
    // Divide: acc[32:0] is the partial remainder, opA[31:0] the divisor, opB shifts dividend out and quotient in.
    always_comb begin
        w_shifted = {i_acc[MDU_WIDTH-1:0], i_opB[MDU_WIDTH-1]};
        w_diff    = {1'b0, w_shifted} - {2'b00, i_opA[MDU_WIDTH-1:0]};
        w_fits    = ~w_diff[MDU_WIDTH+1];
        if (i_isDiv) begin
            o_acc = {{(MDU_WIDTH-1){1'b0}}, (w_fits ? w_diff[MDU_WIDTH:0] : w_shifted)};
            o_opA = i_opA;
            o_opB = {i_opB[MDU_WIDTH-2:0], w_fits};
        end else begin
            o_acc = i_opB[0] ? (i_acc + i_opA) : i_acc;
            o_opA = i_opA << 1;
            o_opB = i_opB >> 1;
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative MIPS-style HI/LO multiply/divide unit: operands are captured on the start edge,
// the FSM leaves IDLE on the next edge. Define MDU_EARLY_TERM_EN to end multiplies early.
module mult_div_sequencer
    import mdu_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           op,
    input  logic [MDU_WIDTH-1:0] operandA,
    input  logic [MDU_WIDTH-1:0] operandB,
    output logic                 busy,
    output logic                 done,
    output logic [MDU_WIDTH-1:0] hi,
    output logic [MDU_WIDTH-1:0] lo,
    output logic                 divByZero
);

`ifdef MDU_EARLY_TERM_EN
    localparam bit EarlyTerm = 1'b1;
`else
    localparam bit EarlyTerm = 1'b0;
`endif

    mduState_e              r_state;
    mduOp_e                 r_op;
    logic                   r_pending;
    logic                   r_negRes;
    logic                   r_negRem;
    logic [4:0]             r_count;
    logic [2*MDU_WIDTH-1:0] r_acc;
    logic [2*MDU_WIDTH-1:0] r_opA;
    logic [MDU_WIDTH-1:0]   r_opB;
    logic                   r_busy;
    logic                   r_done;
    logic [MDU_WIDTH-1:0]   r_hi;
    logic [MDU_WIDTH-1:0]   r_lo;
    logic                   r_divByZero;

    logic                   w_isDiv;
    logic                   w_inSigned;
    logic [MDU_WIDTH-1:0]   w_magA;
    logic [MDU_WIDTH-1:0]   w_magB;
    logic [2*MDU_WIDTH-1:0] w_accNext;
    logic [2*MDU_WIDTH-1:0] w_opANext;
    logic [MDU_WIDTH-1:0]   w_opBNext;
    logic [2*MDU_WIDTH-1:0] w_prod;
    logic [MDU_WIDTH-1:0]   w_remMag;
    logic [MDU_WIDTH-1:0]   w_resHi;
    logic [MDU_WIDTH-1:0]   w_resLo;
    logic [MDU_WIDTH-1:0]   w_div0Hi;
    logic                   w_lastIter;

    assign w_isDiv    = (r_op == MDU_DIV) || (r_op == MDU_DIVU);
    assign w_inSigned = ~op[0];
    assign w_magA     = mduMag(operandA, w_inSigned);
    assign w_magB     = mduMag(operandB, w_inSigned);

    mdu_step u_step (
        .i_isDiv (w_isDiv),
        .i_acc   (r_acc),
        .i_opA   (r_opA),
        .i_opB   (r_opB),
        .o_acc   (w_accNext),
        .o_opA   (w_opANext),
        .o_opB   (w_opBNext)
    );

    // Results are formed from the step outputs so the final iteration and DONE entry share one edge.
    assign w_prod     = r_negRes ? -w_accNext : w_accNext;
    assign w_remMag   = w_accNext[MDU_WIDTH-1:0];
    assign w_resHi    = w_isDiv ? (r_negRem ? -w_remMag : w_remMag) : w_prod[2*MDU_WIDTH-1:MDU_WIDTH];
    assign w_resLo    = w_isDiv ? (r_negRes ? -w_opBNext : w_opBNext) : w_prod[MDU_WIDTH-1:0];
    assign w_div0Hi   = r_negRem ? -r_opB : r_opB;
    assign w_lastIter = (r_count == 5'(MDU_ITER - 1)) ||
                        (EarlyTerm && !w_isDiv && (w_opBNext == '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_op        <= MDU_MULT;
            r_pending   <= 1'b0;
            r_negRes    <= 1'b0;
            r_negRem    <= 1'b0;
            r_count     <= '0;
            r_acc       <= '0;
            r_opA       <= '0;
            r_opB       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_divByZero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (abort) begin
                        r_pending <= 1'b0;
                    end else if (r_pending) begin
                        r_pending <= 1'b0;
                        r_count   <= '0;
                        if (w_isDiv && (r_opA[MDU_WIDTH-1:0] == '0)) begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_hi        <= w_div0Hi;
                            r_lo        <= '1;
                            r_divByZero <= 1'b1;
                        end else if (EarlyTerm && !w_isDiv && (r_opB == '0)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_hi    <= '0;
                            r_lo    <= '0;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end else if (start) begin
                        r_pending   <= 1'b1;
                        r_op        <= mduOp_e'(op);
                        r_acc       <= '0;
                        r_divByZero <= 1'b0;
                        r_negRes    <= w_inSigned & (operandA[MDU_WIDTH-1] ^ operandB[MDU_WIDTH-1]);
                        if (op[1]) begin
                            r_opA    <= {{MDU_WIDTH{1'b0}}, w_magB};
                            r_opB    <= w_magA;
                            r_negRem <= w_inSigned & operandA[MDU_WIDTH-1];
                        end else begin
                            r_opA    <= {{MDU_WIDTH{1'b0}}, w_magA};
                            r_opB    <= w_magB;
                            r_negRem <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                    end else begin
                        r_acc <= w_accNext;
                        r_opA <= w_opANext;
                        r_opB <= w_opBNext;
                        if (w_lastIter) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_hi    <= w_resHi;
                            r_lo    <= w_resLo;
                        end else begin
                            r_count <= r_count + 5'd1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign divByZero = r_divByZero;

endmodule
